// File: rtl/cb_pkg.sv
// Shared constants and helpers for the cb_* register-pipeline blocks.
// Supplies the default word width and a constant-evaluable ceil(log2) helper.
package cb_pkg;

  localparam int CB_DEFAULT_WIDTH = 8;

  // Smallest r with 2**r >= value; usable in parameter/port-width context.
  function automatic int cb_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cb_dff_stage.sv
// One enable/clear register stage carrying a valid bit and a WIDTH-bit word.
// Data loads only when load=1 so the parent can gate it on the incoming valid.
module cb_dff_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (clr) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (en) begin
      valid_reg <= d_valid;
      if (load) begin
        data_reg <= d_data;
      end
    end
  end

  assign q_valid = valid_reg;
  assign q_data  = data_reg;

endmodule

// File: rtl/cb_dff_pipe.sv
// DEPTH-stage valid/data delay pipeline with global stall, sync flush and async reset.
// Define CB_DFF_PIPE_OCC_EN to add the 'occ' output counting valid stages.
module cb_dff_pipe
  import cb_pkg::*;
#(
  parameter int               WIDTH     = CB_DEFAULT_WIDTH,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               GATE_DATA = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
`ifdef CB_DFF_PIPE_OCC_EN
  output logic [cb_clog2(DEPTH+1)-1:0]     occ,
`endif
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data
);

  // Link gi feeds stage gi; link DEPTH is the pipeline output.
  logic             valid_link [DEPTH+1];
  logic [WIDTH-1:0] data_link  [DEPTH+1];

  assign valid_link[0] = in_valid;
  assign data_link[0]  = in_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic load;
      assign load = (GATE_DATA != 0) ? valid_link[gi] : 1'b1;

      cb_dff_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .d_valid (valid_link[gi]),
        .d_data  (data_link[gi]),
        .q_valid (valid_link[gi+1]),
        .q_data  (data_link[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_link[DEPTH];
  assign out_data  = data_link[DEPTH];

`ifdef CB_DFF_PIPE_OCC_EN
  localparam int OCC_W = cb_clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_reg;

  // Word enters while one leaves on the same edge: net change is in - out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_reg <= '0;
    end else if (clr) begin
      occ_reg <= '0;
    end else if (en) begin
      occ_reg <= occ_reg + OCC_W'(in_valid) - OCC_W'(valid_link[DEPTH]);
    end
  end

  assign occ = occ_reg;
`endif

endmodule

// File: tb/tb_cb_dff_pipe.sv
// Directed self-checking bench for cb_dff_pipe: DEPTH=3 ungated, DEPTH=3 gated
// and DEPTH=1 instances share one stimulus stream. Honours CB_DFF_PIPE_OCC_EN.
module tb_cb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       ov, gv, v1;
  logic [7:0] od, gd, d1;
`ifdef CB_DFF_PIPE_OCC_EN
  logic [1:0] occ, occ_g;
  logic [0:0] occ_1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cb_dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .GATE_DATA(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
`ifdef CB_DFF_PIPE_OCC_EN
    .occ(occ),
`endif
    .out_valid(ov), .out_data(od));

  cb_dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .GATE_DATA(1)) u_gate (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
`ifdef CB_DFF_PIPE_OCC_EN
    .occ(occ_g),
`endif
    .out_valid(gv), .out_data(gd));

  cb_dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .GATE_DATA(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
`ifdef CB_DFF_PIPE_OCC_EN
    .occ(occ_1),
`endif
    .out_valid(v1), .out_data(d1));

  // Advance one edge, then settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d en=%0b clr=%0b in=%0b/%h -> out=%0b/%h gate=%0b/%h d1=%0b/%h",
             cyc, en, clr, in_valid, in_data, ov, od, gv, gd, v1, d1);
  endtask

  task automatic flush();
    clr = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%0b exp=0", ov); end
      checks++; if (od !== 8'h00) begin errors++; $display("FAIL reset_hold_data got=%h exp=00", od); end
    end
`ifdef CB_DFF_PIPE_OCC_EN
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occ); end
`endif
    rst = 1'b1;
    tick();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL release_edge1_valid got=%0b exp=0", ov); end
    checks++; if (v1 !== 1'b1 || d1 !== 8'hFF) begin errors++; $display("FAIL depth1_latency got=%0b/%h exp=1/ff", v1, d1); end
    tick();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL release_edge2_valid got=%0b exp=0", ov); end
    tick();
    checks++; if (ov !== 1'b1 || od !== 8'hFF) begin errors++; $display("FAIL release_edge3_out got=%0b/%h exp=1/ff", ov, od); end
    flush();
  endtask

  task automatic test_stream();
    logic [7:0] din  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic       vin  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       vexp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] dexp [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0] oexp [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = vin[k]; in_data = din[k];
      tick();
      checks++; if (ov !== vexp[k]) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=%0b", k, ov, vexp[k]); end
      if (vexp[k]) begin
        checks++; if (od !== dexp[k]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, od, dexp[k]); end
      end
      checks++; if (v1 !== vin[k]) begin errors++; $display("FAIL depth1_valid[%0d] got=%0b exp=%0b", k, v1, vin[k]); end
`ifdef CB_DFF_PIPE_OCC_EN
      checks++; if (occ !== oexp[k]) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=%0d", k, occ, oexp[k]); end
`else
      if (oexp[k] > 2'd3) $display("unreachable occ value");
`endif
    end
  endtask

  task automatic test_stall();
    flush();
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      tick();
    end
    checks++; if (ov !== 1'b1 || od !== 8'h01) begin errors++; $display("FAIL stall_pre got=%0b/%h exp=1/01", ov, od); end
    en = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ov !== 1'b1 || od !== 8'h01) begin errors++; $display("FAIL stall_hold[%0d] got=%0b/%h exp=1/01", k, ov, od); end
    end
    en = 1'b1; in_valid = 1'b1; in_data = 8'h04;
    tick();
    checks++; if (ov !== 1'b1 || od !== 8'h02) begin errors++; $display("FAIL stall_resume0 got=%0b/%h exp=1/02", ov, od); end
    in_valid = 1'b0; in_data = 8'h00;
    tick();
    checks++; if (ov !== 1'b1 || od !== 8'h03) begin errors++; $display("FAIL stall_resume1 got=%0b/%h exp=1/03", ov, od); end
    tick();
    checks++; if (ov !== 1'b1 || od !== 8'h04) begin errors++; $display("FAIL stall_resume2 got=%0b/%h exp=1/04", ov, od); end
    tick();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL stall_drained got=%0b exp=0", ov); end
  endtask

  task automatic test_clear();
    flush();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + k);
      tick();
    end
    clr = 1'b1; en = 1'b0;
    tick();
    checks++; if (ov !== 1'b0 || od !== 8'h00) begin errors++; $display("FAIL clear_out got=%0b/%h exp=0/00", ov, od); end
`ifdef CB_DFF_PIPE_OCC_EN
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL clear_occ got=%0d exp=0", occ); end
`endif
    // Flush with en=1 and a valid input: the input must be discarded too.
    clr = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL clear_discard[%0d] got=%0b exp=0", k, ov); end
    end
  endtask

  task automatic test_gate();
    flush();
    en = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5; tick();
    in_valid = 1'b0; in_data = 8'h00; tick();
    in_valid = 1'b1; in_data = 8'h5A; tick();
    checks++; if (gv !== 1'b1 || gd !== 8'hA5) begin errors++; $display("FAIL gate_out0 got=%0b/%h exp=1/a5", gv, gd); end
    in_valid = 1'b0; in_data = 8'h00; tick();
    checks++; if (gv !== 1'b0 || gd !== 8'hA5) begin errors++; $display("FAIL gate_out1 got=%0b/%h exp=0/a5", gv, gd); end
    checks++; if (ov !== 1'b0 || od !== 8'h00) begin errors++; $display("FAIL ungated_bubble got=%0b/%h exp=0/00", ov, od); end
    tick();
    checks++; if (gv !== 1'b1 || gd !== 8'h5A) begin errors++; $display("FAIL gate_out2 got=%0b/%h exp=1/5a", gv, gd); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] oexp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    flush();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 4); in_data = (k < 4) ? 8'(k + 1) : 8'h00;
      tick();
`ifdef CB_DFF_PIPE_OCC_EN
      checks++; if (occ !== oexp[k]) begin errors++; $display("FAIL mid_occ[%0d] got=%0d exp=%0d", k, occ, oexp[k]); end
`else
      if (oexp[k] > 2'd3) $display("unreachable occ value");
`endif
    end
    checks++; if (ov !== 1'b1 || od !== 8'h03) begin errors++; $display("FAIL mid_pre got=%0b/%h exp=1/03", ov, od); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ov !== 1'b0 || od !== 8'h00) begin errors++; $display("FAIL mid_async_clear got=%0b/%h exp=0/00", ov, od); end
`ifdef CB_DFF_PIPE_OCC_EN
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL mid_async_occ got=%0d exp=0", occ); end
`endif
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_no_survivor[%0d] got=%0b exp=0", k, ov); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_clear();
    test_gate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
